// File: rtl/lif_neuron_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_neuron_ctrl: leak/integrate/compare sequencer and membrane state of one
// leaky integrate-and-fire neuron, driving an external shared ALU.
// Rev 1.0
// ---------------------------------------------------------------------------
module lif_neuron_ctrl #(
  parameter int WIDTH         = 12,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_current,
  input  logic signed [WIDTH-1:0] threshold,
  input  logic signed [WIDTH-1:0] v_reset,
  output logic signed [WIDTH-1:0] alu_a,
  output logic signed [WIDTH-1:0] alu_b,
  output logic [1:0]              alu_fn,
  input  logic signed [WIDTH-1:0] alu_x,
  input  logic                    alu_cmp,
  output logic                    spike,
  output logic signed [WIDTH-1:0] v_mem,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAK, S_INTEG, S_CMP, S_FIRE, S_REFRAC
  } state_t;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_CMP  = 2'b10;
  localparam logic [1:0] FN_HALF = 2'b11;
  localparam logic signed [WIDTH-1:0] V_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] V_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0] REFRAC_LOAD = 8'(REFRAC_CYCLES);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] v_mem_q, v_mem_d;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    spike_q;
  logic                    accept;
  logic                    ovf;

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign busy     = !in_ready;
  assign spike    = spike_q;
  assign v_mem    = v_mem_q;
  assign accept   = in_valid && in_ready;

  // Signed overflow of the integrate add: equal operand signs, result flipped.
  assign ovf = (v_mem_q[WIDTH-1] == cur_q[WIDTH-1]) &&
               (alu_x[WIDTH-1] != v_mem_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    v_mem_d = v_mem_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    alu_fn  = FN_ADD;
    alu_a   = v_mem_q;
    alu_b   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_d   = in_current;
          state_d = S_LEAK;
        end
      end
      S_LEAK: begin
        alu_fn  = FN_HALF;
        v_mem_d = alu_x;
        state_d = S_INTEG;
      end
      S_INTEG: begin
        alu_b   = cur_q;
        v_mem_d = ovf ? (v_mem_q[WIDTH-1] ? V_MIN : V_MAX) : alu_x;
        state_d = S_CMP;
      end
      S_CMP: begin
        alu_fn  = FN_CMP;
        alu_b   = threshold;
        state_d = alu_cmp ? S_IDLE : S_FIRE;
      end
      S_FIRE: begin
        v_mem_d = v_reset;
        cnt_d   = REFRAC_LOAD;
        state_d = (REFRAC_CYCLES == 0) ? S_IDLE : S_REFRAC;
      end
      S_REFRAC: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      v_mem_q <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_mem_q <= v_mem_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      spike_q <= (state_d == S_FIRE);
    end
  end

endmodule
`default_nettype wire

// File: doc/lif_neuron_ctrl.md
# lif_neuron_ctrl

- Sequencing controller and state holder for one leaky integrate-and-fire neuron.
- Sits directly upstream of the neuron ALU and drives its `A`, `B` and `fn_sel` each cycle; it also consumes the ALU's `X` and `cmp_out`.
- It accepts one signed input current per handshake and runs leak, integrate and threshold compare through the ALU. On a threshold crossing it emits a one-cycle spike, resets the membrane potential and then enforces a refractory period.

## Interface
- `WIDTH`, 12: two's-complement data width; must match the ALU.
- `REFRAC_CYCLES`, 4: refractory length in cycles, range 0..255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `in_current` is valid.
- `in_ready` output 1: block can accept a sample.
- `in_current` input WIDTH signed: synaptic input current.
- `threshold` input WIDTH signed: firing threshold; quasi-static.
- `v_reset` input WIDTH signed: post-spike potential; quasi-static.
- `alu_a` output WIDTH signed: drives ALU `A`.
- `alu_b` output WIDTH signed: drives ALU `B`.
- `alu_fn` output 2: drives ALU `fn_sel`. Encoding: 00 add, 01 sub, 10 cmp, 11 `A>>>1`.
- `alu_x` input WIDTH signed: ALU result `X`.
- `alu_cmp` input 1: ALU `cmp_out`, which is (B > A), signed.
- `spike` output 1: registered one-cycle spike pulse.
- `v_mem` output WIDTH signed: registered membrane potential.
- `busy` output 1: equals `!in_ready`.

## Operation
- States: IDLE, LEAK, INTEG, CMP, FIRE, REFRAC.
- Accept: `in_valid && in_ready` at a clock edge.
  - `in_current` is captured into an internal register `cur`.
  - IDLE goes to LEAK.
- IDLE:
  - `in_ready` = 1.
  - `alu_fn`=00, `alu_a`=`v_mem`, `alu_b`=0.
  - `v_mem` holds.
- LEAK:
  - `alu_fn`=11, `alu_a`=`v_mem`.
  - `v_mem` <= `alu_x`, an arithmetic halve that rounds toward minus infinity.
  - Goes to INTEG.
- INTEG:
  - `alu_fn`=00, `alu_a`=`v_mem`, `alu_b`=`cur`.
  - Saturation: if `v_mem` and `cur` have the same sign and `alu_x` has the opposite sign, `v_mem` <= 2^(WIDTH-1)-1 when positive, or -2^(WIDTH-1) when negative.
  - Otherwise `v_mem` <= `alu_x`.
  - Goes to CMP.
- CMP:
  - `alu_fn`=10, `alu_a`=`v_mem`, `alu_b`=`threshold`.
  - `fire` = `!alu_cmp`, i.e. `v_mem` >= `threshold`.
  - If `fire`, go to FIRE; otherwise go to IDLE.
  - `alu_cmp` is sampled only in CMP; it is undefined in all other states.
- FIRE:
  - `spike` = 1 for exactly this cycle.
  - At the edge leaving FIRE: `v_mem` <= `v_reset` and the refractory counter loads `REFRAC_CYCLES`.
  - Goes to REFRAC, or directly to IDLE if `REFRAC_CYCLES`=0.
- REFRAC:
  - `in_ready` = 0.
  - The counter decrements each cycle; leave to IDLE when it reaches 1.
  - `v_mem` holds `v_reset`; no leak is applied.
- In every state except IDLE, `alu_b` defaults to 0 when not otherwise specified.
- `threshold` and `v_reset` are used only in CMP and FIRE respectively. Changes to them take effect on the next sample.

## Timing
- Reset values (edge with `rst_n`=0):
  - state = IDLE, `v_mem`=0, `cur`=0, counter=0, `spike`=0.
  - `in_ready`=0 while `rst_n`=0; `in_ready`=1 in the first cycle after release.
- `in_ready` = (state==IDLE) && `rst_n`. This is combinational from registers only; there is no combinational path from `in_valid`.
- Non-firing sample:
  - Accept at edge E0; LEAK, INTEG and CMP occupy cycles 1 to 3.
  - `in_ready`=1 again in cycle 4.
  - Throughput is one sample per 4 cycles.
- Firing sample:
  - `spike`=1 in cycle 4 (FIRE).
  - `v_mem`=`v_reset` from cycle 5.
  - `in_ready` stays 0 for cycles 5 to 4+`REFRAC_CYCLES` and returns to 1 in cycle 5+`REFRAC_CYCLES`.
- `in_valid` held high while `in_ready`=0 is not accepted. The upstream block holds its data, and the sample is accepted at the first edge with `in_ready`=1.
- Reset mid-operation, in any state: the next cycle is IDLE with `v_mem`=0.
  - No spike is emitted.
  - A pending refractory period is cancelled.
  - A sample in flight is dropped.
- `v_mem` updates only at LEAK, INTEG and FIRE edges and at reset.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required: `v_mem`=0, `spike`=0, `in_ready`=0 during reset and 1 in the first cycle after release.
- Subthreshold accumulation, with `threshold`=100, `v_reset`=0, `REFRAC_CYCLES`=4:
  - Input 40 gives `v_mem`=40, no spike.
  - Input 40 gives leak 20, then 60, no spike.
  - Input 80 gives leak 30, then 110. `spike` pulses in cycle 4; `v_mem`=0; `in_ready` is low for 5 cycles after the CMP cycle.
- Equality fires: from `v_mem`=0 with `threshold`=100, input 100. Required: spike, and `v_mem` goes to `v_reset`=-5.
- Saturation, with `threshold`=2047:
  - Inputs 2000 then 2000 give leak 1000 and a sum that saturates to 2047, which spikes.
  - With `threshold`=0 and `v_reset`=0 from `v_mem`=0: inputs -2048 then -2048 give -2048 with no spike.
- Negative leak and back-pressure:
  - From `v_mem`=-3, input 0 gives `v_mem`=-2, no spike.
  - `in_valid` held high through the refractory period is accepted exactly once, on the first IDLE edge.
- Reset mid-operation: drive `rst_n`=0 during INTEG of a sample that would fire. Required: no spike, `v_mem`=0, IDLE after release.
